// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback: execute-stage retirement for the ARM ALU.
// Evaluates each instruction's condition against the architectural NZCV
// register, applies S-bit / compare flag updates, and holds a one-entry
// registered writeback for the register file. Counts executed and skipped
// instructions and feeds the C flag back to the ALU carry input.
//
// Handshake: an input transfer happens on a cycle where in_valid && in_ready;
// a writeback transfer happens where wb_valid && wb_ready. in_ready is
// !wb_valid || wb_ready, so a held entry is replaced by a new acceptance in
// the same cycle it drains, and upstream must hold in_valid and its payload
// stable until accepted.
module alu_flag_writeback #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [3:0]       opcode,
    input  logic             s_bit,
    input  logic [3:0]       rd,
    input  logic [31:0]      alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             shifter_c,
    output logic [3:0]       flags,
    output logic             carry_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_we,
    output logic [3:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    logic f_n, f_z, f_c, f_v;
    logic pass;
    logic accept;
    logic is_compare;
    logic is_arith;
    logic flag_write;

    assign f_n = flags[3];
    assign f_z = flags[2];
    assign f_c = flags[1];
    assign f_v = flags[0];

    assign in_ready   = !wb_valid || wb_ready;
    assign accept     = in_valid && in_ready;
    assign carry_out  = flags[1];
    assign is_compare = (opcode[3:2] == 2'b10);
    assign flag_write = accept && pass && (is_compare || s_bit);

    // Condition evaluation against the flags as they stand this cycle.
    always_comb begin
        pass = 1'b0;
        case (cond)
            4'b0000: pass = f_z;
            4'b0001: pass = !f_z;
            4'b0010: pass = f_c;
            4'b0011: pass = !f_c;
            4'b0100: pass = f_n;
            4'b0101: pass = !f_n;
            4'b0110: pass = f_v;
            4'b0111: pass = !f_v;
            4'b1000: pass = f_c && !f_z;
            4'b1001: pass = !f_c || f_z;
            4'b1010: pass = (f_n == f_v);
            4'b1011: pass = (f_n != f_v);
            4'b1100: pass = !f_z && (f_n == f_v);
            4'b1101: pass = f_z || (f_n != f_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;  // 1111: never
        endcase
    end

    // Arithmetic opcodes take C and V from the adder; the rest are logical.
    always_comb begin
        is_arith = 1'b0;
        case (opcode)
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010, 4'b1011: is_arith = 1'b1;
            default:                            is_arith = 1'b0;
        endcase
    end

    // Architectural flag register; logical ops keep V and take C from the shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flag_write) begin
            if (is_arith) begin
                flags <= {alu_n, alu_z, alu_c, alu_v};
            end else begin
                flags <= {alu_n, alu_z, shifter_c, f_v};
            end
        end
    end

    // One-entry writeback; failing instructions still retire with wb_we low.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 4'd0;
            wb_data  <= 32'd0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_we    <= pass && !is_compare;
            wb_rd    <= rd;
            wb_data  <= alu_result;
        end else if (wb_valid && wb_ready) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end
    end

    // Executed / skipped counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_count <= '0;
            skip_count <= '0;
        end else if (accept) begin
            if (pass) begin
                exec_count <= exec_count + 1'b1;
            end else begin
                skip_count <= skip_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Testbench for alu_flag_writeback: directed scenarios plus a randomized run,
// all checked against a behavioural model of the retirement rules.
module tb_alu_flag_writeback;

    localparam int CNT_W = 2;
    localparam int SW    = 44 + 2 * CNT_W;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [3:0]       opcode;
    logic             s_bit;
    logic [3:0]       rd;
    logic [31:0]      alu_result;
    logic             alu_n, alu_z, alu_c, alu_v;
    logic             shifter_c;
    logic [3:0]       flags;
    logic             carry_out;
    logic             wb_valid;
    logic             wb_ready;
    logic             wb_we;
    logic [3:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    int tests = 0;
    int fails = 0;

    alu_flag_writeback #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .opcode(opcode), .s_bit(s_bit), .rd(rd),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z),
        .alu_c(alu_c), .alu_v(alu_v), .shifter_c(shifter_c),
        .flags(flags), .carry_out(carry_out), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .exec_count(exec_count), .skip_count(skip_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Flags kept as named bits; writeback entries in a scoreboard queue
    // holding {rd, data} of every accepted instruction since reset.
    bit m_n, m_z, m_c, m_v;
    bit m_wbv, m_we;
    int m_exec, m_skip;
    bit last_acc;
    logic [35:0] exp_q[$];

    function automatic bit model_pass(input logic [3:0] c);
        case (c)
            4'd0:    return m_z;                          // EQ
            4'd1:    return !m_z;                         // NE
            4'd2:    return m_c;                          // CS
            4'd3:    return !m_c;                         // CC
            4'd4:    return m_n;                          // MI
            4'd5:    return !m_n;                         // PL
            4'd6:    return m_v;                          // VS
            4'd7:    return !m_v;                         // VC
            4'd8:    return m_c && !m_z;                  // HI
            4'd9:    return !m_c || m_z;                  // LS
            4'd10:   return m_n == m_v;                   // GE
            4'd11:   return m_n != m_v;                   // LT
            4'd12:   return !m_z && (m_n == m_v);         // GT
            4'd13:   return m_z || (m_n != m_v);          // LE
            4'd14:   return 1'b1;                         // AL
            default: return 1'b0;                         // never
        endcase
    endfunction

    task automatic model_step();
        bit acc, p, cmp, arith;
        int op;
        last_acc = 1'b0;
        if (reset) begin
            {m_n, m_z, m_c, m_v} = 4'b0000;
            m_wbv = 0; m_we = 0; m_exec = 0; m_skip = 0;
            exp_q.delete();
            return;
        end
        acc = in_valid && (!m_wbv || wb_ready);
        last_acc = acc;
        if (acc) begin
            op    = int'(opcode);
            p     = model_pass(cond);
            cmp   = (op >= 8 && op <= 11);
            arith = (op >= 2 && op <= 7) || op == 10 || op == 11;
            if (p) m_exec = (m_exec + 1) % (1 << CNT_W);
            else   m_skip = (m_skip + 1) % (1 << CNT_W);
            if (p && (cmp || s_bit)) begin
                m_n = alu_n;
                m_z = alu_z;
                if (arith) begin
                    m_c = alu_c;
                    m_v = alu_v;
                end else begin
                    m_c = shifter_c;
                end
            end
            m_wbv = 1;
            m_we  = p && !cmp;
            exp_q.push_back({rd, alu_result});
        end else if (m_wbv && wb_ready) begin
            m_wbv = 0;
            m_we  = 0;
        end
    endtask

    function automatic logic [SW-1:0] exp_state();
        logic [35:0] ent;
        logic [CNT_W-1:0] e, s;
        ent = (exp_q.size() > 0) ? exp_q[$] : 36'd0;
        e = CNT_W'(m_exec);
        s = CNT_W'(m_skip);
        return {m_n, m_z, m_c, m_v, m_c, m_wbv, m_we, ent, e, s,
                (!m_wbv || wb_ready)};
    endfunction

    function automatic logic [SW-1:0] obs_state();
        return {flags, carry_out, wb_valid, wb_we, wb_rd, wb_data,
                exec_count, skip_count, in_ready};
    endfunction

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic drive(input bit v, input logic [3:0] c, input logic [3:0] op,
                         input bit s, input logic [3:0] r, input logic [31:0] res,
                         input logic [3:0] nzcv, input bit sc, input bit wr,
                         input bit rst);
        in_valid = v; cond = c; opcode = op; s_bit = s; rd = r;
        alu_result = res; {alu_n, alu_z, alu_c, alu_v} = nzcv;
        shifter_c = sc; wb_ready = wr; reset = rst;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 4'hE, 4'h4, 1, 4'h7, 32'hDEAD_BEEF, 4'hF, 1, 1, 1);
        drive(0, 4'hE, 4'h0, 0, 4'h0, 32'h0, 4'h0, 0, 1, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 4'hE, 4'h4, 1, 4'h7, 32'hDEAD_BEEF, 4'hF, 1, 1, 1);
        drive(1, 4'hE, 4'h4, 1, 4'h7, 32'hDEAD_BEEF, 4'hF, 1, 1, 1);
        tests++;
        if ({flags, wb_valid, in_ready, exec_count, skip_count, carry_out, wb_we}
            !== {4'b0000, 1'b0, 1'b1, {CNT_W{1'b0}}, {CNT_W{1'b0}}, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: flags=%b wbv=%b rdy=%b exec=%0d skip=%0d cout=%b we=%b, want 0000 0 1 0 0 0 0",
                     flags, wb_valid, in_ready, exec_count, skip_count, carry_out, wb_we);
        end
        tests++;
        if (obs_state() !== exp_state()) begin
            fails++;
            $display("FAIL reset_model: got %h want %h", obs_state(), exp_state());
        end
    endtask

    task automatic test_adds();
        do_reset();
        drive(1, 4'hE, 4'h4, 1, 4'h3, 32'h8000_0000, 4'b1001, 0, 1, 0);
        tests++;
        if ({flags, wb_valid, wb_we, wb_rd, wb_data, exec_count}
            !== {4'b1001, 1'b1, 1'b1, 4'h3, 32'h8000_0000, CNT_W'(1)}) begin
            fails++;
            $display("FAIL adds: flags=%b wbv=%b we=%b rd=%0d data=%h exec=%0d, want 1001 1 1 3 80000000 1",
                     flags, wb_valid, wb_we, wb_rd, wb_data, exec_count);
        end
        tests++;
        if (carry_out !== 1'b0) begin
            fails++;
            $display("FAIL adds_carry: got %b want 0", carry_out);
        end
    endtask

    task automatic test_dependent();
        do_reset();
        drive(1, 4'hE, 4'hA, 0, 4'h1, 32'h0, 4'b0110, 0, 1, 0);   // CMP
        tests++;
        if ({flags, wb_we, carry_out} !== {4'b0110, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL cmp: flags=%b we=%b cout=%b, want 0110 0 1", flags, wb_we, carry_out);
        end
        drive(1, 4'h0, 4'hD, 0, 4'h2, 32'h55, 4'b0000, 0, 1, 0);  // MOVEQ
        tests++;
        if ({wb_we, wb_rd, flags} !== {1'b1, 4'h2, 4'b0110}) begin
            fails++;
            $display("FAIL moveq: we=%b rd=%0d flags=%b, want 1 2 0110", wb_we, wb_rd, flags);
        end
        drive(1, 4'h1, 4'hD, 0, 4'h4, 32'h66, 4'b0000, 0, 1, 0);  // MOVNE
        tests++;
        if ({wb_valid, wb_we, exec_count, skip_count}
            !== {1'b1, 1'b0, CNT_W'(2), CNT_W'(1)}) begin
            fails++;
            $display("FAIL movne: wbv=%b we=%b exec=%0d skip=%0d, want 1 0 2 1",
                     wb_valid, wb_we, exec_count, skip_count);
        end
    endtask

    task automatic test_logical_s();
        do_reset();
        drive(1, 4'hE, 4'hA, 0, 4'h0, 32'h0, 4'b0001, 0, 1, 0);   // CMP presets 0001
        drive(1, 4'hE, 4'h0, 1, 4'h5, 32'h0, 4'b0100, 1, 1, 0);   // ANDS
        tests++;
        if ({flags, carry_out} !== {4'b0111, 1'b1}) begin
            fails++;
            $display("FAIL ands_flags: flags=%b cout=%b, want 0111 1", flags, carry_out);
        end
        tests++;
        if (obs_state() !== exp_state()) begin
            fails++;
            $display("FAIL ands_model: got %h want %h", obs_state(), exp_state());
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] snap;
        do_reset();
        drive(1, 4'hE, 4'h4, 1, 4'h6, 32'hAAAA_0001, 4'b0010, 0, 0, 0);  // A
        snap = obs_state();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'hE, 4'h2, 1, 4'h9, 32'hBBBB_0002, 4'b1000, 0, 0, 0);  // B held
            tests++;
            if (in_ready !== 1'b0 || obs_state() !== snap) begin
                fails++;
                $display("FAIL stall_%0d: rdy=%b state=%h want rdy=0 state=%h",
                         i, in_ready, obs_state(), snap);
            end
        end
        wb_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready: got %b want 1", in_ready);
        end
        drive(1, 4'hE, 4'h2, 1, 4'h9, 32'hBBBB_0002, 4'b1000, 0, 1, 0);
        tests++;
        if ({wb_valid, wb_rd, wb_data, flags, exec_count}
            !== {1'b1, 4'h9, 32'hBBBB_0002, 4'b1000, CNT_W'(2)}) begin
            fails++;
            $display("FAIL release_entry: wbv=%b rd=%0d data=%h flags=%b exec=%0d, want 1 9 bbbb0002 1000 2",
                     wb_valid, wb_rd, wb_data, flags, exec_count);
        end
        drive(0, 4'hE, 4'h0, 0, 4'h0, 32'h0, 4'h0, 0, 1, 0);
        tests++;
        if ({wb_valid, wb_we} !== 2'b00) begin
            fails++;
            $display("FAIL drain: wbv=%b we=%b, want 0 0", wb_valid, wb_we);
        end
    endtask

    task automatic test_never_wrap_reset();
        do_reset();
        drive(1, 4'hE, 4'hA, 0, 4'h0, 32'h0, 4'b1010, 0, 1, 0);   // flags 1010
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'hF, 4'h4, 1, 4'h8, 32'h1234, 4'b0101, 1, 1, 0);
            tests++;
            if ({flags, wb_we, wb_valid, skip_count}
                !== {4'b1010, 1'b0, 1'b1, CNT_W'(i % 4)}) begin
                fails++;
                $display("FAIL never_%0d: flags=%b we=%b wbv=%b skip=%0d, want 1010 0 1 %0d",
                         i, flags, wb_we, wb_valid, skip_count, i % 4);
            end
        end
        // Entry held under backpressure, then reset on the stall.
        drive(1, 4'hE, 4'hD, 0, 4'h3, 32'h77, 4'h0, 0, 0, 0);
        drive(1, 4'hE, 4'hD, 0, 4'h4, 32'h88, 4'h0, 0, 0, 1);
        tests++;
        if ({wb_valid, flags, exec_count, skip_count}
            !== {1'b0, 4'b0000, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
            fails++;
            $display("FAIL stall_reset: wbv=%b flags=%b exec=%0d skip=%0d, want 0 0000 0 0",
                     wb_valid, flags, exec_count, skip_count);
        end
    endtask

    task automatic test_random();
        bit v = 0, held = 0;
        logic [3:0] c = 0, op = 0, r = 0, nzcv = 0;
        bit s = 0, sc = 0, wr, rst;
        logic [31:0] res = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!held) begin
                v    = ($urandom_range(0, 3) != 0);
                c    = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
                op   = 4'($urandom_range(0, 15));
                s    = $urandom_range(0, 1);
                r    = 4'($urandom_range(0, 15));
                res  = $urandom;
                nzcv = 4'($urandom_range(0, 15));
                sc   = $urandom_range(0, 1);
            end
            wr  = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 79) == 0);
            drive(v, c, op, s, r, res, nzcv, sc, wr, rst);
            held = v && !last_acc && !rst;
            tests++;
            if (obs_state() !== exp_state()) begin
                fails++;
                $display("FAIL random_%0d: got %h want %h", i, obs_state(), exp_state());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        in_valid = 0; cond = 0; opcode = 0; s_bit = 0; rd = 0; alu_result = 0;
        alu_n = 0; alu_z = 0; alu_c = 0; alu_v = 0; shifter_c = 0;
        wb_ready = 1; reset = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_adds();
        test_dependent();
        test_logical_s();
        test_backpressure();
        test_never_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_flag_writeback.md
# alu_flag_writeback

Execute-stage retirement block directly downstream of the ARM ALU. It captures the ALU result and NZCV flags for each instruction, and evaluates the instruction's condition field against the architectural flag register. It then updates the flags according to ARM S-bit and compare rules, and presents a one-entry registered writeback to the register file. It also feeds the current C flag back to the ALU carry input, for ADC, SBC and RSC.

## Interface
Parameters:
- CNT_W, 16, width of the executed and skipped instruction counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  an ALU result is presented.
- in_ready  out  1  block accepts this cycle; equals !wb_valid || wb_ready.
- cond  in  4  ARM condition field.
- opcode  in  4  ALU opcode (0000 AND … 1111 MVN).
- s_bit  in  1  set-flags request.
- rd  in  4  destination register.
- alu_result  in  32  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags.
- shifter_c  in  1  shifter-operand carry, used for logical ops.
- flags  out  4  architectural {N,Z,C,V}.
- carry_out  out  1  equals flags[1]; wired to ALU carryIn.
- wb_valid  out  1  writeback entry held.
- wb_ready  in  1  register file consumes the entry.
- wb_we  out  1  entry writes the register file.
- wb_rd  out  4  destination register of the entry.
- wb_data  out  32  data of the entry.
- exec_count  out  CNT_W  instructions accepted with condition passing.
- skip_count  out  CNT_W  instructions accepted with condition failing.

## Operation
- An instruction is accepted on a cycle where in_valid && in_ready.
- The condition pass signal is computed combinationally from the flags register as it stands on the acceptance cycle:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 is treated as never (pass=0).
- Flag update happens only on acceptance with pass=1. It applies when opcode is 10xx (TST, TEQ, CMP, CMN), or when s_bit=1.
  - Arithmetic opcodes (0010–0111, 1010, 1011): NZCV ← alu_n, alu_z, alu_c, alu_v.
  - Logical opcodes (0000, 0001, 1000, 1001, 1100–1111): N ← alu_n, Z ← alu_z, C ← shifter_c, V unchanged.
- Writeback register load on acceptance:
  - wb_valid ← 1, wb_rd ← rd, wb_data ← alu_result.
  - wb_we ← pass && opcode[3:2]!=2'b10.
  - A failing instruction still retires an entry, with wb_we=0, to preserve in-order retirement.
- When wb_valid && wb_ready and no acceptance occurs, wb_valid ← 0 and wb_we ← 0.
- Counters: exec_count increments on acceptance with pass=1; skip_count increments on acceptance with pass=0. Both wrap modulo 2^CNT_W.
- Reset values: flags=0000, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, exec_count=0, skip_count=0. Consequently in_ready=1 and carry_out=0.

## Timing
- Latency is 1 cycle from acceptance to wb_valid=1 with the entry's fields.
- Updated flags are visible on flags and carry_out on the cycle after acceptance.
- The next accepted instruction evaluates cond against the updated flags, with no bubble.
- Throughput is 1 per cycle while wb_ready=1. A held entry and a new acceptance in the same cycle replace the entry; there is no gap.
- Backpressure: when wb_valid=1 and wb_ready=0, in_ready=0.
  - wb_* fields, flags and counters hold stable.
  - in_valid and payload must be held by the upstream.
- Reset asserted mid-operation: the held entry is discarded, flags clear, and counters clear on the same edge. An in_valid on a reset cycle is not accepted.
- Counter wrap: from 2^CNT_W−1 the next increment yields 0, with no sticky bit.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 → flags=0000, wb_valid=0, in_ready=1, both counters 0, carry_out=0.
- ADDS: cond=1110, opcode=0100, s_bit=1, rd=3, result=0x80000000, NZCV=1001 → next cycle flags=1001, wb_valid=1, wb_we=1, wb_rd=3, wb_data=0x80000000, exec_count=1.
- Dependent conditions: CMP with NZCV=0110, then MOV (1101) with cond=EQ on the next cycle, then MOV with cond=NE → CMP gives wb_we=0; MOVEQ gives wb_we=1; MOVNE gives wb_we=0. Counts end at exec_count=2, skip_count=1.
- Logical S-bit: flags preset to 0001; ANDS with alu_v=0, alu_c=0, shifter_c=1, alu_z=1 → flags=0111, i.e. V retained and C taken from shifter_c.
- Backpressure: wb_ready=0 with two instructions queued → in_ready=0 and wb entry, flags and counters stable for 5 cycles. Then wb_ready=1 → second instruction accepted that cycle, and its entry appears next cycle.
- Never, wrap and reset during stall: cond=1111 with s_bit=1 → flags unchanged, wb_we=0, skip_count++. With CNT_W=2, four skipped instructions → skip_count=0. Reset during a stall → wb_valid=0 the next cycle.
